// File: rtl/convert_to_bcd.sv
// Iterative binary-to-BCD converter (double-dabble) with a start/busy/done handshake.
// Operands above the largest N_DIGITS-digit decimal value saturate to all nines and raise overflow.
module convert_to_bcd #(
  parameter int N_DIGITS = 8,
  parameter int IN_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     sourceNum,
  output logic [4*N_DIGITS-1:0]   result,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

  function automatic logic [63:0] max_decimal(input int n_digits);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < n_digits; i++) begin
      m = m * 64'd10;
    end
    return m - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL = max_decimal(N_DIGITS);
  localparam logic [BCD_W-1:0] SAT_VAL = {N_DIGITS{4'h9}};

  // Handshake: start is honoured only in ST_IDLE; busy is high from the accepting
  // edge until the FINISH edge; done pulses for the single cycle after that edge.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    result_q, result_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [3:0]          digit;
  logic                bcd_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == LAST_ITER) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    bcd_adj    = '0;
    digit      = '0;
    bcd_carry  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = sourceNum;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(sourceNum) > MAX_VAL);
        end
      end
      ST_SHIFT: begin
        for (int k = 0; k < N_DIGITS; k++) begin
          digit = bcd_q[4*k +: 4];
          bcd_adj[4*k +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
        end
        // A bit leaving the top digit can only happen for out-of-range operands,
        // so folding it into the pending flag keeps the saturation decision safe.
        {bcd_carry, bcd_d} = {bcd_adj, shift_q[IN_WIDTH-1]};
        shift_d    = {shift_q[IN_WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + CNT_W'(1);
        ovf_pend_d = ovf_pend_q | bcd_carry;
      end
      ST_FINISH: begin
        result_d   = ovf_pend_q ? SAT_VAL : bcd_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_convert_to_bcd.sv
// Bench for convert_to_bcd: scenario tasks compared against a decimal reference model.
module tb_convert_to_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] sourceNum;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  convert_to_bcd #(.N_DIGITS(8), .IN_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sourceNum (sourceNum),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: repeated division by ten, saturating above eight decimal digits.
  function automatic logic [31:0] ref_bcd(input logic [31:0] val);
    logic [31:0] r;
    longint unsigned v;
    r = '0;
    v = longint'(val);
    if (v > 64'd99_999_999) return 32'h9999_9999;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] val);
    return (val > 32'd99_999_999);
  endfunction

  function automatic longint unsigned decode_bcd(input logic [31:0] r);
    longint unsigned sum;
    longint unsigned w;
    logic [3:0] d;
    sum = 0;
    w = 1;
    for (int k = 0; k < 8; k++) begin
      d = r[4*k +: 4];
      sum = sum + longint'(d) * w;
      w = w * 10;
    end
    return sum;
  endfunction

  function automatic bit digits_valid(input logic [31:0] r);
    logic [3:0] d;
    for (int k = 0; k < 8; k++) begin
      d = r[4*k +: 4];
      if (d > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Pulses start for one edge and waits (bounded) for done; lat counts edges after acceptance.
  task automatic run_conv(input logic [31:0] val, output logic [31:0] res,
                          output logic ovf, output int lat);
    @(negedge clk);
    sourceNum = val;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sourceNum = $urandom();
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    res = result;
    ovf = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    sourceNum = 32'd123;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_conv(input string name, input logic [31:0] val);
    logic [31:0] res;
    logic ovf;
    int lat;
    run_conv(val, res, ovf, lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL %s_latency: got %0d want 33", name, lat); end
    checks++;
    if (res !== ref_bcd(val)) begin errors++; $display("FAIL %s_result: got %h want %h", name, res, ref_bcd(val)); end
    checks++;
    if (ovf !== ref_ovf(val)) begin errors++; $display("FAIL %s_overflow: got %b want %b", name, ovf, ref_ovf(val)); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: done still %b one cycle later", name, done); end
  endtask

  task automatic test_basic_busy();
    int lat;
    @(negedge clk);
    sourceNum = 32'd1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_window: cycle %0d busy=%b want 1", c, busy); end
      @(posedge clk);
      #1;
      if (done) begin lat = c; break; end
    end
    checks++;
    if (lat != 33) begin errors++; $display("FAIL busy_latency: got %0d want 33", lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", busy); end
    checks++;
    if (result !== 32'h0000_1234) begin errors++; $display("FAIL basic_1234: got %h want 00001234", result); end
    @(posedge clk);
  endtask

  task automatic test_ignore_start();
    int n_done;
    int first_done;
    n_done = 0;
    first_done = -1;
    @(negedge clk);
    sourceNum = 32'd1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        start = 1'b1;
        sourceNum = 32'd5678;
      end
      @(posedge clk);
      #1;
      if (c == 10) start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        checks++;
        if (result !== 32'h0000_1234) begin errors++; $display("FAIL ignore_result: got %h want 00001234", result); end
      end
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
    checks++;
    if (first_done != 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", first_done); end
    check_conv("after_ignore", 32'd5678);
  endtask

  task automatic test_reset_abort();
    int n_done;
    n_done = 0;
    @(negedge clk);
    sourceNum = 32'd87_654_321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h want 00000000", result); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", n_done); end
    check_conv("restart", 32'd87_654_321);
  endtask

  // start held high across done: the edge in FINISH is ignored, the next one accepts.
  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    int c1;
    int c2;
    a = $urandom_range(0, 99_999_999);
    b = $urandom_range(0, 99_999_999);
    @(negedge clk);
    sourceNum = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    sourceNum = b;
    c1 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin c1 = c; break; end
    end
    checks++;
    if (c1 != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", c1); end
    checks++;
    if (result !== ref_bcd(a)) begin errors++; $display("FAIL b2b_first_result: got %h want %h", result, ref_bcd(a)); end
    c2 = -1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) begin
        start = 1'b0;
        checks++;
        if (result !== ref_bcd(a) || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold: result %h busy %b want %h busy 1", result, busy, ref_bcd(a));
        end
      end
      if (done) begin c2 = c; break; end
    end
    start = 1'b0;
    checks++;
    if (c2 != 34) begin errors++; $display("FAIL b2b_period: got %0d want 34", c2); end
    checks++;
    if (result !== ref_bcd(b)) begin errors++; $display("FAIL b2b_second_result: got %h want %h", result, ref_bcd(b)); end
  endtask

  task automatic test_random_sweep();
    logic [31:0] v;
    logic [31:0] res;
    logic ovf;
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      v = $urandom_range(0, 99_999_999);
      run_conv(v, res, ovf, lat);
      checks++;
      if (lat != 33 || decode_bcd(res) != longint'(v) || !digits_valid(res) || ovf !== 1'b0) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: in %0d got %h ovf %b lat %0d want %h ovf 0 lat 33",
                   i, v, res, ovf, lat, ref_bcd(v));
      end
    end
  endtask

  task automatic test_random_overflow();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(32'd100_000_000, 32'hFFFF_FFFF);
      check_conv("rand_ovf", v);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sourceNum = '0;
    test_reset();
    check_conv("zero", 32'd0);
    test_basic_busy();
    check_conv("max_in_range", 32'd99_999_999);
    check_conv("just_over", 32'd100_000_000);
    check_conv("all_ones", 32'hFFFF_FFFF);
    check_conv("after_ovf", 32'd9);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random_overflow();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
